// File: rtl/uart_rx_massiv_receiver.sv
// UART receiver that collects frames into a small array of packs with per-pack error flags.
// The frame format and parameter set match the massiv transmitter, so both ends share one wire.
`timescale 1ns/1ps
module uart_rx_massiv_receiver #(
    parameter int UART_BAUD_RATE           = 9600,
    parameter int CLOCK_FREQUENCY          = 38400,
    parameter int PARITY                   = 1,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int NUMBER_STOP_BITS         = 3,
    parameter int RX_MASSIV_DEEP           = 2,
    parameter int RX_MASSIV_DEEP_LOG_2     = $clog2(RX_MASSIV_DEEP)
) (
    input  logic                                                 IN_CLOCK,
    input  logic                                                 IN_RESET_N,
    input  logic                                                 RX_PORT,
    input  logic                                                 IN_RX_CLEAR_BUFFER,
    output logic [NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP-1:0]   OUT_RX_DATA_MASSIV,
    output logic [RX_MASSIV_DEEP-1:0]                            OUT_RX_ERROR,
    output logic [RX_MASSIV_DEEP_LOG_2:0]                        OUT_RX_NUM_OF_DATA_PACKS_READY,
    output logic                                                 OUT_RX_OVERFLOW,
    output logic                                                 OUT_RX_BUSY
);
    localparam int N    = NUM_OF_DATA_BITS_IN_PACK;
    localparam int CLKS = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int MID  = CLKS / 2;
    localparam int TW   = $clog2(CLKS);
    localparam int BW   = $clog2(N + NUMBER_STOP_BITS);
    localparam int CW   = RX_MASSIV_DEEP_LOG_2 + 1;

    localparam logic [TW-1:0] T_MID       = TW'(MID - 1);
    localparam logic [TW-1:0] T_LAST      = TW'(CLKS - 1);
    localparam logic [BW-1:0] B_DATA_LAST = BW'(N - 1);
    localparam logic [BW-1:0] B_STOP_LAST = BW'(NUMBER_STOP_BITS - 1);
    localparam logic [CW-1:0] FULL        = CW'(RX_MASSIV_DEEP);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, STORE} state_t;

    state_t          state, state_nxt;
    logic            s_meta, rxs;
    logic [1:0]      sync_vld;
    logic            armed;
    logic [TW-1:0]   timer;
    logic [BW-1:0]   bit_cnt;
    logic [N-1:0]    shreg;
    logic            par_err, frm_err;
    logic            sample;

    assign OUT_RX_BUSY = (state != IDLE);

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sample    = 1'b0;
        case (state)
            IDLE:  if (armed && !rxs) state_nxt = START;
            START: if (timer == T_MID) begin
                       sample    = 1'b1;
                       state_nxt = rxs ? IDLE : DATA;
                   end
            DATA:  if (timer == T_LAST) begin
                       sample = 1'b1;
                       if (bit_cnt == B_DATA_LAST) state_nxt = (PARITY != 0) ? PAR : STOP;
                   end
            PAR:   if (timer == T_LAST) begin
                       sample    = 1'b1;
                       state_nxt = STOP;
                   end
            STOP:  if (timer == T_LAST) begin
                       sample = 1'b1;
                       if (bit_cnt == B_STOP_LAST) state_nxt = STORE;
                   end
            STORE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Armed only once the synchroniser carries a real line value that is high, so a
    // frame cut by reset is ignored until the line idles again.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            s_meta   <= 1'b1;
            rxs      <= 1'b1;
            sync_vld <= '0;
            armed    <= 1'b0;
            timer    <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            s_meta   <= RX_PORT;
            rxs      <= s_meta;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rxs) armed <= 1'b1;

            timer <= (state == IDLE || sample) ? '0 : timer + 1'b1;

            if (state_nxt != state) bit_cnt <= '0;
            else if (sample)        bit_cnt <= bit_cnt + 1'b1;

            if (state == IDLE) begin
                par_err <= 1'b0;
                frm_err <= 1'b0;
            end
            if (sample && state == DATA) shreg <= {rxs, shreg[N-1:1]};
            if (sample && state == PAR)  par_err <= (^shreg) ^ rxs ^ (PARITY == 2);
            if (sample && state == STOP && !rxs) frm_err <= 1'b1;
        end
    end

    // Clear has priority over a coinciding store.
    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            OUT_RX_DATA_MASSIV             <= '0;
            OUT_RX_ERROR                   <= '0;
            OUT_RX_NUM_OF_DATA_PACKS_READY <= '0;
            OUT_RX_OVERFLOW                <= 1'b0;
        end else if (IN_RX_CLEAR_BUFFER) begin
            OUT_RX_DATA_MASSIV             <= '0;
            OUT_RX_ERROR                   <= '0;
            OUT_RX_NUM_OF_DATA_PACKS_READY <= '0;
            OUT_RX_OVERFLOW                <= 1'b0;
        end else if (state == STORE) begin
            if (OUT_RX_NUM_OF_DATA_PACKS_READY == FULL) begin
                OUT_RX_OVERFLOW <= 1'b1;
            end else begin
                for (int k = 0; k < RX_MASSIV_DEEP; k++) begin
                    if (CW'(k) == OUT_RX_NUM_OF_DATA_PACKS_READY) begin
                        OUT_RX_DATA_MASSIV[k*N +: N] <= shreg;
                        OUT_RX_ERROR[k]              <= par_err | frm_err;
                    end
                end
                OUT_RX_NUM_OF_DATA_PACKS_READY <= OUT_RX_NUM_OF_DATA_PACKS_READY + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_massiv_receiver.md
Name: uart_rx_massiv_receiver

Overview:
Standalone UART array receiver: deserialises frames from RX_PORT and stores them in a buffer of RX_MASSIV_DEEP packs with per-pack error flags. It is the receiving counterpart of the massiv transmitter path, used wherever a block only listens (loopback checkers, command sinks). Frame format and parameter set match UART_TX_RX_MASSIV_MODULE, so the two interoperate on one wire.

Parameters:
UART_BAUD_RATE, 9600, line bit rate
CLOCK_FREQUENCY, 38400, IN_CLOCK frequency in Hz; CLKS_PER_BIT = CLOCK_FREQUENCY/UART_BAUD_RATE (integer division, must be >=4)
PARITY, 1, 0 = none, 1 = even, 2 = odd
NUM_OF_DATA_BITS_IN_PACK, 8, data bits per frame, LSB first
NUMBER_STOP_BITS, 3, stop bits per frame (1..4)
RX_MASSIV_DEEP, 2, buffer depth in packs (>=1)
RX_MASSIV_DEEP_LOG_2, $clog2(RX_MASSIV_DEEP), derived

Ports:
IN_CLOCK  input  1  system clock, rising edge
IN_RESET_N  input  1  asynchronous active-low reset
RX_PORT  input  1  serial line, idle high, asynchronous to IN_CLOCK
IN_RX_CLEAR_BUFFER  input  1  level; empties the buffer while high
OUT_RX_DATA_MASSIV  output  NUM_OF_DATA_BITS_IN_PACK*RX_MASSIV_DEEP  pack k at bits [N*(k+1)-1 : N*k]
OUT_RX_ERROR  output  RX_MASSIV_DEEP  bit k = pack k had a parity or framing error
OUT_RX_NUM_OF_DATA_PACKS_READY  output  RX_MASSIV_DEEP_LOG_2+1  packs stored, 0..RX_MASSIV_DEEP
OUT_RX_OVERFLOW  output  1  sticky; a frame arrived while the buffer was full
OUT_RX_BUSY  output  1  high while state != IDLE

Behaviour:
- Clock and reset: one clock domain. IN_RESET_N is asynchronous active-low reset.
- Reset values: all outputs 0, state IDLE, both synchroniser flops 1.
- RX_PORT passes through a 2-flop synchroniser, initialised to 1. All sampling uses the synchronised signal (rxs).
- Bit timer: counts 0..CLKS_PER_BIT-1. MID = CLKS_PER_BIT/2.
- IDLE: when rxs = 0, go to START and clear the timer.
- START: at timer = MID-1, sample rxs.
  - rxs = 1 is a glitch: return to IDLE; nothing stored.
  - rxs = 0: go to DATA. Each subsequent sample is taken CLKS_PER_BIT cycles after the previous one.
- DATA: sample NUM_OF_DATA_BITS_IN_PACK bits, LSB first, into a shift register.
- PARITY state (skipped when PARITY = 0): sample one bit. Parity error if data XOR parity bit is 1 (even) or 0 (odd).
- STOP: sample NUMBER_STOP_BITS bits. Any 0 sets the framing error.
- STORE: single cycle, then IDLE. No wait for the end of the last stop bit, so back-to-back frames are accepted.
- STORE with count < DEEP:
  - data written to slot [count];
  - OUT_RX_ERROR[count] = parity_err | framing_err;
  - count increments.
  - Outputs change on the clock edge leaving STORE, i.e. 2 cycles after the last stop-bit sample.
- STORE with count = DEEP (full): frame discarded; buffer and count unchanged; OUT_RX_OVERFLOW set to 1.
- IN_RX_CLEAR_BUFFER high, sampled each clock:
  - count, OUT_RX_DATA_MASSIV, OUT_RX_ERROR and OUT_RX_OVERFLOW go to 0 on the next edge.
  - A frame in progress is not aborted.
  - A STORE coinciding with clear is dropped: clear wins.
- Unfilled slots read 0. Slots are never overwritten until cleared.
- Reset asserted mid-frame: immediate return to IDLE and all outputs 0. The remainder of the frame on the line is ignored until the line is seen high, then low again.
- Line held low permanently: after a framing-error STORE, IDLE sees rxs = 0 and restarts. Each such frame is stored with its error flag set.

Test Plan:
- Defaults (CLKS_PER_BIT = 4, even parity, 3 stop): send 0xA5 then 0x3C correctly framed -> READY goes 1 then 2; DATA_MASSIV = 16'h3CA5; ERROR = 2'b00; OVERFLOW = 0.
- Send 0x5A with the parity bit inverted -> READY = 1; DATA[7:0] = 8'h5A; ERROR = 2'b01.
- Send 0x11 with the second stop bit driven 0 -> ERROR[0] = 1; next correct frame 0x22 -> DATA = 16'h2211; ERROR = 2'b01.
- Fill the buffer with 0x01 and 0x02, then send 0x03 -> READY stays 2; DATA = 16'h0201; OVERFLOW = 1. Pulse IN_RX_CLEAR_BUFFER for 10 cycles -> READY = 0, DATA = 0, OVERFLOW = 0. Then send 0x03 -> DATA[7:0] = 8'h03.
- Pull RX_PORT low for 1 clock only -> state returns to IDLE; READY stays 0.
- Assert IN_RESET_N low during data bit 3 of a frame, release it, then send 0x77 -> READY = 1 and DATA[7:0] = 8'h77. The aborted frame is not stored.
